// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/exec/mem/wb, traps, counts retires.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  fn3,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_d,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       wbsel_q;

  logic is_alu, is_jmp, is_br, is_fence;
  logic is_ld, is_st, is_ecall, legal;
  logic in_mem, tmo;

  assign is_alu   = (opcode == OP_LUI) ||
                    (opcode == OP_AUIPC) ||
                    (opcode == OP_IMM) ||
                    (opcode == OP_OP);
  assign is_jmp   = (opcode == OP_JAL) ||
                    (opcode == OP_JALR);
  assign is_br    = (opcode == OP_BR);
  assign is_fence = (opcode == OP_FENCE);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_ecall = (opcode == OP_SYS) &&
                    (fn3 == 3'b000);
  assign legal    = is_alu || is_jmp || is_br ||
                    is_fence || is_ld || is_st;

  // The IR is stable from DECODE onward, so the
  // opcode still describes the in-flight instruction.
  assign in_mem = (state == FETCH) || (state == MEM);
  assign tmo    = in_mem && !mem_ready &&
                  (cnt == CNT_LAST);

  assign state_o = state;

  // Strobes decoded from state and inputs; held low in reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel_d = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        EXEC: begin
          if (is_jmp) begin
            pc_we  = 1'b1;
            pc_sel = 1'b1;
          end else if (is_br) begin
            pc_we  = branch_taken;
            pc_sel = 1'b1;
          end
        end
        MEM: begin
          mem_req   = 1'b1;
          mem_sel_d = 1'b1;
          mem_we    = is_st;
        end
        WB: begin
          rf_we  = 1'b1;
          wb_sel = wbsel_q;
        end
        default: ;
      endcase
    end
  end

  // State sequencing, trap capture, wait counter, instret.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      cnt        <= '0;
      wbsel_q    <= 2'd0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      instret    <= 32'd0;
    end else begin
      if (in_mem && !mem_ready)
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
      unique case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
          end else if (tmo) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
          end
        end
        DECODE: begin
          if (legal) begin
            state <= EXEC;
          end else begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= is_ecall ? 2'd2 : 2'd1;
          end
        end
        EXEC: begin
          unique case (1'b1)
            is_alu: begin
              state   <= WB;
              wbsel_q <= 2'd0;
            end
            is_jmp: begin
              state   <= WB;
              wbsel_q <= 2'd2;
            end
            is_br, is_fence: begin
              state   <= FETCH;
              instret <= instret + 32'd1;
            end
            is_ld, is_st: state <= MEM;
            default: state <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (is_st) begin
              state   <= FETCH;
              instret <= instret + 32'd1;
            end else begin
              state   <= WB;
              wbsel_q <= 2'd1;
            end
          end else if (tmo) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
          end
        end
        WB: begin
          state   <= FETCH;
          instret <= instret + 32'd1;
        end
        default: state <= TRAP;
      endcase
    end
  end

endmodule
